axi_mem_master: RTL and testbench
=================================

// Module: axi_mem_master
// PURPOSE
// AXI4 master (initiator) that turns simple command/stream requests into single
// INCR bursts on a 32-bit AXI4 port. It is the counterpart of the team's AXI4
// block-RAM slave: it drives memory from local logic and returns read beats as
// a valid/ready stream. One transaction in flight at a time.
// PARAMETERS
// G_ID     1'b0   constant value driven on m_axi_awid / m_axi_arid
// G_WSTRB  1      1: forward wr_strb to m_axi_wstrb; 0: drive 4'hF
// PORTS
// s_aclk         in   1   clock
// s_aresetn      in   1   reset; asynchronous assert, active-low
// cmd_valid      in   1   command request
// cmd_ready      out  1   command accepted when valid&ready
// cmd_write      in   1   1 = write burst, 0 = read burst
// cmd_addr       in   32  byte address; bits [1:0] ignored and driven as 0
// cmd_len        in   8   beats-1 (AXI len encoding)
// wr_data        in   32  write beat data
// wr_strb        in   4   write beat strobes
// wr_valid/ready in/out 1 write beat stream handshake
// rd_data        out  32  read beat data
// rd_last        out  1   final beat of the read burst
// rd_valid/ready out/in 1 read beat stream handshake
// done           out  1   one-cycle pulse when a transaction completes
// resp           out  2   response of the last transaction (held until next done)
// err_last       out  1   one-cycle pulse: RLAST did not match the beat count
// m_axi_aw*      out      awid[0:0] awaddr[31:0] awlen[7:0] awsize[2:0] awburst[1:0] awvalid; awready in
// m_axi_w*       out      wdata[31:0] wstrb[3:0] wlast wvalid; wready in
// m_axi_b*       in       bid[0:0] bresp[1:0] bvalid; bready out
// m_axi_ar*      out      arid araddr arlen arsize arburst arvalid; arready in
// m_axi_r*       in       rid rdata[31:0] rresp[1:0] rlast rvalid; rready out
// BEHAVIOUR
// - Reset: FSM=IDLE; cmd_ready, awvalid, wvalid, bready, arvalid, rready, done,
//   err_last = 0; resp = 2'b00; addr/len registers = 0. cmd_ready rises the first
//   clock after reset release.
// - Constants: awsize/arsize = 3'b010, awburst/arburst = 2'b01 (INCR).
// - FSM: IDLE -> (cmd_write? AW : AR). AW -> W on awvalid&awready. W -> B on the
//   wlast beat handshake. B -> IDLE on bvalid (bready=1 throughout B). AR -> R on
//   arready. R -> IDLE on a beat handshake where rlast=1 or beat counter = 0.
// - cmd_ready = 1 only in IDLE. Command registered on accept; awvalid/arvalid are
//   asserted the next cycle and held, with address and len stable, until ready.
// - W: wvalid = wr_valid, wr_ready = m_axi_wready, wdata/wstrb pass through
//   combinationally. wvalid is never asserted before the AW handshake. An 8-bit
//   down-counter loads cmd_len. wlast = (count == 0). Decrement on each beat.
// - R: rd_valid = m_axi_rvalid, m_axi_rready = rd_ready (only in R), rd_data = rdata.
//   rd_last = rlast. The counter decrements per beat. resp accumulates the max rresp.
// - RLAST mismatch (rlast with count != 0, or count == 0 without rlast): err_last
//   pulses, resp = 2'b10, FSM -> IDLE. Further stray R beats are ignored.
// - done pulses the cycle after B accept or the final R beat. resp = bresp / rresp.
// - Min latency, single-beat write: cmd accept N, awvalid N+1, wvalid N+2, bready
//   N+3; done the cycle after bvalid.
// - No 4 KB boundary splitting: bursts that cross 4 KB are caller error, not checked.
// - Reset mid-transaction: all valids/readies drop immediately (async) and the
//   transaction is abandoned. The slave must be reset together with this block.
// STRUCTURE
// - Shared package axi_mem_pkg: AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR
//   constants and the state enum {IDLE, AW, W, B, AR, R}.
// - Single module, no sub-module: one registered FSM plus a beat counter.
// TESTING (bench pairs this master with the AXI4 block-RAM slave)
// 1. Write addr 0x10, len 0, data 0xDEADBEEF -> awaddr 0x10, awlen 0, one beat
//    with wlast=1; done pulses with resp 2'b00.
// 2. Write 4 beats at 0x40 (data 1..4), then read 4 beats at 0x40 -> rd_data
//    1,2,3,4; rd_last on beat 4 only; two done pulses.
// 3. 8-beat read with rd_ready toggling every cycle -> m_axi_rready mirrors it;
//    8 beats delivered, none lost or duplicated.
// 4. Slave holds awready low 5 cycles -> awvalid/awaddr stable; wvalid stays 0
//    until the AW handshake.
// 5. Model bresp=2'b10 -> resp 2'b10 at done. rlast on beat 2 of 4 -> err_last
//    pulses, resp 2'b10, cmd_ready=1 next cycle.
// 6. Assert s_aresetn low after beat 2 of 4 -> outputs 0 without waiting for a
//    clock edge; cmd_ready=1 one clock after release.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared AXI4 constants and master FSM state encoding
package axi_mem_pkg;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;
endpackage

// File: rtl/axi_mem_master.sv
// axi_mem_master: single-outstanding AXI4 INCR burst master driven by a command/stream interface
module axi_mem_master
  import axi_mem_pkg::*;
#(
  parameter logic [0:0] G_ID    = 1'b0,
  parameter bit         G_WSTRB = 1'b1
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic [1:0]  resp,
  output logic        err_last,
  output logic [0:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [0:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [0:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [0:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [1:0]  resp_q, resp_d, racc_q, racc_d, r_max;
  logic        done_q, done_d, err_q, err_d, live_q;
  logic        w_hs, r_hs, r_end, r_bad;
  logic        unused_in;
  assign unused_in = ^{m_axi_bid, m_axi_rid, cmd_addr[1:0]};
  always_comb begin
    w_hs    = state_q == W && wr_valid && m_axi_wready;
    r_hs    = state_q == R && m_axi_rvalid && rd_ready;
    r_end   = m_axi_rlast || cnt_q == 8'd0;
    r_bad   = m_axi_rlast != (cnt_q == 8'd0);
    r_max   = m_axi_rresp > racc_q ? m_axi_rresp : racc_q;
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    racc_d  = racc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid && live_q) begin
        state_d = cmd_write ? AW : AR;
        addr_d  = {cmd_addr[31:2], 2'b00};
        len_d   = cmd_len;
        cnt_d   = cmd_len;
        racc_d  = AXI_RESP_OKAY;
      end
      AW: state_d = m_axi_awready ? W : AW;
      W: if (w_hs) begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? B : W;
      end
      B: if (m_axi_bvalid) begin
        state_d = IDLE;
        done_d  = 1'b1;
        resp_d  = m_axi_bresp;
      end
      AR: state_d = m_axi_arready ? R : AR;
      R: if (r_hs) begin
        cnt_d  = cnt_q - 8'd1;
        racc_d = r_max;
        // a premature or missing RLAST ends the burst with SLVERR
        if (r_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = r_bad;
          resp_d  = r_bad ? AXI_RESP_SLVERR : r_max;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= AXI_RESP_OKAY;
      racc_q  <= AXI_RESP_OKAY;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      racc_q  <= racc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end
  assign cmd_ready     = state_q == IDLE && live_q;
  assign m_axi_awid    = G_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = state_q == AW;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = G_WSTRB ? wr_strb : 4'hF;
  assign m_axi_wlast   = cnt_q == 8'd0;
  assign m_axi_wvalid  = state_q == W && wr_valid;
  assign wr_ready      = state_q == W && m_axi_wready;
  assign m_axi_bready  = state_q == B;
  assign m_axi_arid    = G_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = state_q == AR;
  assign m_axi_rready  = state_q == R && rd_ready;
  assign rd_valid      = state_q == R && m_axi_rvalid;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = m_axi_rlast;
  assign done          = done_q;
  assign resp          = resp_q;
  assign err_last      = err_q;
endmodule

// File: tb/tb_axi_mem_master.sv
// tb_axi_mem_master: transaction table against a behavioural block-RAM slave, plus reset corner case
module tb_axi_mem_master;
  logic        clk, rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready, done, err_last;
  logic [1:0]  resp;
  logic [0:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  axi_mem_master #(.G_ID(1'b0), .G_WSTRB(1'b1)) dut (
    .s_aclk(clk), .s_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .resp(resp), .err_last(err_last),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(1'b0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(1'b0), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural slave; knobs set per transaction
  logic [31:0] mem [0:255];
  int          aw_dly, rl_cfg, aw_wait, rbeat, rlen;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        w_act, r_act;
  logic [31:0] waddr, raddr;
  assign awready = !w_act && aw_wait >= aw_dly;
  assign wready  = w_act;
  assign arready = !r_act;
  assign rresp   = rresp_cfg;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_act <= 1'b0; r_act <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      aw_wait <= 0; bresp <= 2'b00; rdata <= '0; rbeat <= 0; rlen <= 0;
      waddr <= '0; raddr <= '0;
    end else begin
      if (awvalid && awready) begin
        w_act <= 1'b1; waddr <= awaddr; aw_wait <= 0;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && w_act) begin
        mem[waddr[9:2]] <= wdata;
        waddr <= waddr + 32'd4;
        if (wlast) begin w_act <= 1'b0; bvalid <= 1'b1; bresp <= bresp_cfg; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        r_act <= 1'b1; rvalid <= 1'b1; rbeat <= 0; raddr <= araddr; rlen <= int'(arlen);
        rdata <= mem[araddr[9:2]];
        rlast <= arlen == 8'd0 || rl_cfg == 1;
      end else if (rvalid && rready) begin
        if (rlast) begin
          rvalid <= 1'b0; r_act <= 1'b0;
        end else begin
          rbeat <= rbeat + 1;
          rdata <= mem[int'(raddr[9:2]) + rbeat + 1];
          rlast <= (rbeat + 1 == rlen) || (rbeat + 2 == rl_cfg);
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          aw_dly;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    int          rl;
    bit          tog;
    logic [1:0]  eresp;
    bit          eerr;
  } vec_t;
  vec_t tv [11];
  int checks = 0, errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic xfer(input vec_t v);
    int beats = 0, a_c = -1, aw_c = -1, w_c = -1, b_c = -1, d_c = -1, aw_n = 0, err_n = 0;
    int exp_beats;
    bit acc = 0, fin = 0;
    exp_beats = v.wr ? int'(v.len) + 1 : (v.rl != 0 ? v.rl : int'(v.len) + 1);
    aw_dly = v.aw_dly; bresp_cfg = v.bresp; rresp_cfg = v.rresp; rl_cfg = v.rl;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      cmd_valid = !acc;
      wr_valid  = v.wr && acc && beats <= int'(v.len);
      wr_data   = v.base + 32'(beats);
      wr_strb   = 4'(beats) ^ 4'hA;
      rd_ready  = v.tog ? c[0] : 1'b1;
      #1;
      if (cmd_valid && cmd_ready) begin acc = 1; a_c = c; end
      if (awvalid) begin
        if (aw_c < 0) aw_c = c;
        aw_n++;
        chk("awaddr", awaddr, v.addr & ~32'h3);
        chk("awlen", 32'(awlen), 32'(v.len));
        chk("wvalid_before_aw", 32'(wvalid), 0);
      end
      if (arvalid) begin
        chk("araddr", araddr, v.addr & ~32'h3);
        chk("arlen", 32'(arlen), 32'(v.len));
      end
      if (wvalid && w_c < 0) w_c = c;
      if (wr_valid && wr_ready) begin
        chk("wdata", wdata, v.base + 32'(beats));
        chk("wstrb", 32'(wstrb), 32'(4'(beats) ^ 4'hA));
        chk("wlast", 32'(wlast), 32'(beats == int'(v.len)));
        beats++;
      end
      if (bready && b_c < 0) b_c = c;
      if (rd_valid) chk("rready_mirror", 32'(rready), 32'(rd_ready));
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, v.base + 32'(beats));
        chk("rd_last", 32'(rd_last), 32'(beats == exp_beats - 1));
        beats++;
      end
      if (err_last) err_n++;
      if (done) begin fin = 1; d_c = c; end
    end
    chk("timeout", 32'(fin), 1);
    chk("resp", 32'(resp), 32'(v.eresp));
    chk("err_last", 32'(err_n), 32'(v.eerr));
    chk("beats", 32'(beats), 32'(exp_beats));
    chk("cmd_ready_after", 32'(cmd_ready), 1);
    if (v.wr) chk("aw_cycles", 32'(aw_n), 32'(v.aw_dly + 1));
    if (v.wr && v.len == 8'd0 && v.aw_dly == 0) begin
      chk("lat_aw", 32'(aw_c - a_c), 1);
      chk("lat_w", 32'(w_c - a_c), 2);
      chk("lat_b", 32'(b_c - a_c), 3);
      chk("lat_done", 32'(d_c - a_c), 4);
    end
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 0);
    chk("err_pulse", 32'(err_last), 0);
    chk("resp_hold", 32'(resp), 32'(v.eresp));
  endtask

  initial begin
    int nb = 0;
    tv[0]  = '{1'b1, 32'h10, 8'd0, 32'hDEADBEEF, 0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[1]  = '{1'b1, 32'h40, 8'd3, 32'h1,        0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[2]  = '{1'b0, 32'h40, 8'd3, 32'h1,        0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[3]  = '{1'b1, 32'h80, 8'd7, 32'h100,      0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[4]  = '{1'b0, 32'h80, 8'd7, 32'h100,      0, 2'b00, 2'b00, 0, 1'b1, 2'b00, 1'b0};
    tv[5]  = '{1'b1, 32'hC3, 8'd1, 32'h50,       5, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[6]  = '{1'b1, 32'h10, 8'd0, 32'h77,       0, 2'b10, 2'b00, 0, 1'b0, 2'b10, 1'b0};
    tv[7]  = '{1'b0, 32'h40, 8'd3, 32'h1,        0, 2'b00, 2'b00, 2, 1'b0, 2'b10, 1'b1};
    tv[8]  = '{1'b0, 32'hC0, 8'd1, 32'h50,       0, 2'b00, 2'b01, 0, 1'b0, 2'b01, 1'b0};
    tv[9]  = '{1'b0, 32'h10, 8'd0, 32'h77,       0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    tv[10] = '{1'b0, 32'h40, 8'd0, 32'h1,        0, 2'b00, 2'b00, 0, 1'b0, 2'b00, 1'b0};
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    aw_dly = 0; rl_cfg = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    #1;
    chk("reset_outputs", 32'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, done, err_last, resp}), 0);
    chk("reset_awaddr", awaddr, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("cmd_ready_release", 32'(cmd_ready), 0);
    @(negedge clk);
    #1;
    chk("cmd_ready_first_clk", 32'(cmd_ready), 1);
    for (int i = 0; i < 10; i++) xfer(tv[i]);
    // abandon a 4-beat read after its second beat
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 8'd3; rd_ready = 1'b1;
    rl_cfg = 0; rresp_cfg = 2'b00;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 50 && nb < 2; c++) begin
      @(negedge clk);
      #1;
      if (rd_valid && rd_ready) nb++;
    end
    chk("mid_beats", 32'(nb), 2);
    @(posedge clk);
    #1;
    chk("mid_rready", 32'(rready), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done, err_last, resp}), 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("cmd_ready_release2", 32'(cmd_ready), 0);
    @(negedge clk);
    #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);
    xfer(tv[10]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
